// File: rtl/keypad_conditioner.sv
// Keypad front end: synchronises and debounces ten digit buttons plus the program button,
// then qualifies the digit vector so the lock FSM sees only a single held digit or nothing.
module keypad_conditioner #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_WIDTH       = 5
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [9:0] raw_b,
  input  logic       raw_program,
  output logic [9:0] b,
  output logic       program_out,
  output logic       key_press,
  output logic [3:0] key_code,
  output logic       multi_key
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(DEBOUNCE_CYCLES);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  typedef enum logic [1:0] {IDLE, KEY, BLOCK} state_t;

  logic [9:0]           sync1_b, sync2_b;
  logic                 sync1_p, sync2_p;
  logic [9:0]           cand_b, stable_b;
  logic [CNT_WIDTH-1:0] cnt_b;
  logic                 cand_p, stable_p;
  logic [CNT_WIDTH-1:0] cnt_p;

  state_t     state, state_nxt;
  logic [9:0] b_nxt;
  logic [3:0] code_nxt;
  logic       press_nxt;
  logic [3:0] idx;
  logic       single;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1_b <= '0;
      sync2_b <= '0;
      sync1_p <= 1'b0;
      sync2_p <= 1'b0;
    end else begin
      sync1_b <= raw_b;
      sync2_b <= sync1_b;
      sync1_p <= raw_program;
      sync2_p <= sync2_p ^ sync2_p ^ sync1_p;
    end
  end

  // Stable is written on the edge the counter reaches the limit, so a clean
  // edge lands on stable exactly DEBOUNCE_CYCLES samples after it is synchronised.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cand_b   <= '0;
      cnt_b    <= '0;
      stable_b <= '0;
    end else if (sync2_b != cand_b) begin
      cand_b <= sync2_b;
      cnt_b  <= CNT_ONE;
    end else if (cnt_b < CNT_MAX) begin
      cnt_b <= cnt_b + CNT_ONE;
      if (cnt_b == CNT_MAX - CNT_ONE) stable_b <= cand_b;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cand_p   <= 1'b0;
      cnt_p    <= '0;
      stable_p <= 1'b0;
    end else if (sync2_p != cand_p) begin
      cand_p <= sync2_p;
      cnt_p  <= CNT_ONE;
    end else if (cnt_p < CNT_MAX) begin
      cnt_p <= cnt_p + CNT_ONE;
      if (cnt_p == CNT_MAX - CNT_ONE) stable_p <= cand_p;
    end
  end

  assign program_out = stable_p;

  always_comb begin
    idx = '0;
    for (int unsigned i = 0; i < 10; i++) begin
      if (stable_b[i]) idx = 4'(i);
    end
  end

  assign single = $onehot(stable_b);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      b         <= '0;
      key_code  <= '0;
      key_press <= 1'b0;
    end else begin
      state     <= state_nxt;
      b         <= b_nxt;
      key_code  <= code_nxt;
      key_press <= press_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    b_nxt     = b;
    code_nxt  = key_code;
    press_nxt = 1'b0;
    unique case (state)
      IDLE: begin
        b_nxt = '0;
        if (single) begin
          state_nxt = KEY;
          b_nxt     = stable_b;
          code_nxt  = idx;
          press_nxt = 1'b1;
        end else if (stable_b != '0) begin
          state_nxt = BLOCK;
        end
      end
      KEY: begin
        if (stable_b == '0) begin
          state_nxt = IDLE;
          b_nxt     = '0;
        end else if (stable_b != b) begin
          state_nxt = BLOCK;
          b_nxt     = '0;
        end
      end
      BLOCK: begin
        b_nxt = '0;
        if (stable_b == '0) state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
        b_nxt     = '0;
      end
    endcase
  end

  assign multi_key = (state == BLOCK);

  a_b_onehot0: assert property (@(posedge clock) disable iff (!reset) $onehot0(b));

endmodule

// File: tb/tb_keypad_conditioner.sv
// Bench for keypad_conditioner: window-based reference model checked every cycle,
// plus directed scenarios with hand-computed timing at DEBOUNCE_CYCLES=4.
module tb_keypad_conditioner;

  localparam int DB = 4;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [9:0] raw_b = '0;
  logic       raw_program = 1'b0;
  logic [9:0] b;
  logic       program_out, key_press, multi_key;
  logic [3:0] key_code;

  int tests = 0;
  int fails = 0;
  bit run = 1'b0;

  keypad_conditioner #(.DEBOUNCE_CYCLES(DB), .CNT_WIDTH(3)) dut (
    .clock(clock), .reset(reset), .raw_b(raw_b), .raw_program(raw_program),
    .b(b), .program_out(program_out), .key_press(key_press),
    .key_code(key_code), .multi_key(multi_key)
  );

  always #5 clock = ~clock;

  function automatic void chk(string name, logic [9:0] act, logic [9:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  // Model: a value becomes stable once the last DB synchronised samples all agree;
  // the qualifier accepts a lone key, blocks on anything else until full release.
  logic [9:0] rb1 = '0, rb2 = '0;
  logic       rp1 = 1'b0, rp2 = 1'b0;
  logic [9:0] hb [DB];
  logic       hp [DB];
  int         nseen = 0;
  logic [9:0] m_sb = '0, m_b = '0;
  logic       m_p = 1'b0, m_kp = 1'b0, m_blk = 1'b0;
  logic [3:0] m_code = '0;

  always @(posedge clock or negedge reset) begin : model
    logic [9:0] s, nb;
    logic       sp, nblk, nkp, allb, allp;
    logic [3:0] nc;
    if (!reset) begin
      rb1 <= '0; rb2 <= '0; rp1 <= 1'b0; rp2 <= 1'b0;
      nseen <= 0; m_sb <= '0; m_b <= '0; m_p <= 1'b0;
      m_kp <= 1'b0; m_blk <= 1'b0; m_code <= '0;
      for (int i = 0; i < DB; i++) begin
        hb[i] <= '0;
        hp[i] <= 1'b0;
      end
    end else begin
      s = rb2;
      sp = rp2;
      rb2 <= rb1; rb1 <= raw_b;
      rp2 <= rp1; rp1 <= raw_program;
      nb = m_b; nc = m_code; nblk = m_blk; nkp = 1'b0;
      if (m_blk) begin
        if (m_sb == '0) nblk = 1'b0;
      end else if (m_b != '0) begin
        if (m_sb != m_b) begin
          nb = '0;
          nblk = (m_sb != '0);
        end
      end else if ($countones(m_sb) == 1) begin
        nb = m_sb;
        nkp = 1'b1;
        for (int i = 0; i < 10; i++) if (m_sb[i]) nc = 4'(i);
      end else if (m_sb != '0) begin
        nblk = 1'b1;
      end
      m_b <= nb; m_code <= nc; m_blk <= nblk; m_kp <= nkp;
      allb = (nseen + 1 >= DB);
      allp = allb;
      for (int i = 0; i < DB - 1; i++) begin
        if (hb[i] != s) allb = 1'b0;
        if (hp[i] != sp) allp = 1'b0;
      end
      if (allb) m_sb <= s;
      if (allp) m_p <= sp;
      hb[0] <= s;
      hp[0] <= sp;
      for (int i = 1; i < DB; i++) begin
        hb[i] <= hb[i-1];
        hp[i] <= hp[i-1];
      end
      if (nseen < DB) nseen <= nseen + 1;
    end
  end

  always @(negedge clock) begin
    if (run) begin
      chk("model_b", b, m_b);
      chk("model_program_out", 10'(program_out), 10'(m_p));
      chk("model_key_press", 10'(key_press), 10'(m_kp));
      chk("model_key_code", 10'(key_code), 10'(m_code));
      chk("model_multi_key", 10'(multi_key), 10'(m_blk));
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clock);
  endtask

  initial begin
    cyc(2);
    chk("rst_b", b, 10'h000);
    chk("rst_kp", 10'(key_press), 10'd0);
    chk("rst_code", 10'(key_code), 10'd0);
    chk("rst_multi", 10'(multi_key), 10'd0);
    chk("rst_prog", 10'(program_out), 10'd0);
    #1 reset = 1'b1;
    run = 1'b1;
    cyc(5);

    // single key press and release
    raw_b = 10'h008;
    cyc(6); chk("t1_b_pre", b, 10'h000);
    cyc(1); chk("t1_b", b, 10'h008);
    chk("t1_kp", 10'(key_press), 10'd1);
    chk("t1_code", 10'(key_code), 10'd3);
    cyc(1); chk("t1_kp_one", 10'(key_press), 10'd0);
    cyc(12);
    raw_b = 10'h000;
    cyc(6); chk("t1_rel_pre", b, 10'h008);
    cyc(1); chk("t1_rel", b, 10'h000);
    cyc(10);

    // short glitches never qualify
    for (int k = 0; k < 4; k++) begin
      raw_b = 10'h020; cyc(3);
      raw_b = 10'h000; cyc(1);
    end
    cyc(10);
    chk("t2_b", b, 10'h000);
    chk("t2_code", 10'(key_code), 10'd3);

    // second key added, partial release stays blocked
    raw_b = 10'h001;
    cyc(15); chk("t3_b", b, 10'h001);
    raw_b = 10'h201;
    cyc(6); chk("t3_b_pre", b, 10'h001);
    cyc(1); chk("t3_b_blk", b, 10'h000);
    chk("t3_multi", 10'(multi_key), 10'd1);
    raw_b = 10'h001;
    cyc(10); chk("t3_still_blk", 10'(multi_key), 10'd1);
    chk("t3_still_b", b, 10'h000);
    raw_b = 10'h000;
    cyc(6); chk("t3_rel_pre", 10'(multi_key), 10'd1);
    cyc(1); chk("t3_rel", 10'(multi_key), 10'd0);
    chk("t3_code", 10'(key_code), 10'd0);
    cyc(5);

    // simultaneous two-key press
    raw_b = 10'h006;
    cyc(7); chk("t4_b", b, 10'h000);
    chk("t4_multi", 10'(multi_key), 10'd1);
    chk("t4_kp", 10'(key_press), 10'd0);
    chk("t4_code", 10'(key_code), 10'd0);
    raw_b = 10'h000;
    cyc(10);

    // program button during a held digit
    raw_b = 10'h004;
    cyc(8); chk("t5_b", b, 10'h004);
    chk("t5_code", 10'(key_code), 10'd2);
    raw_program = 1'b1;
    cyc(5); chk("t5_prog_pre", 10'(program_out), 10'd0);
    cyc(1); chk("t5_prog", 10'(program_out), 10'd1);
    chk("t5_b_hold", b, 10'h004);
    cyc(4);
    raw_program = 1'b0;
    cyc(5); chk("t5_prog_hold", 10'(program_out), 10'd1);
    cyc(1); chk("t5_prog_rel", 10'(program_out), 10'd0);
    chk("t5_b_after", b, 10'h004);
    raw_b = 10'h000;
    cyc(10);

    // reset pulse while a key is held
    raw_b = 10'h010;
    cyc(8); chk("t6_b", b, 10'h010);
    #1 reset = 1'b0;
    #1 chk("t6_b_rst", b, 10'h000);
    chk("t6_code_rst", 10'(key_code), 10'd0);
    cyc(1);
    #1 reset = 1'b1;
    cyc(6); chk("t6_b_pre", b, 10'h000);
    chk("t6_kp_pre", 10'(key_press), 10'd0);
    cyc(1); chk("t6_b_back", b, 10'h010);
    chk("t6_kp", 10'(key_press), 10'd1);
    chk("t6_code", 10'(key_code), 10'd4);
    cyc(1); chk("t6_kp_one", 10'(key_press), 10'd0);
    raw_b = 10'h000;
    cyc(10);

    run = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/keypad_conditioner.md
Name: keypad_conditioner

Overview:
- Front-end stage for the programmable lock FSM. Takes the ten raw digit buttons and the raw program button from the board.
- Synchronises, debounces and validates them, then produces the clean one-hot digit levels and the program level that the lock FSM consumes.
- Rejects multi-key presses and roll-over, so the lock only ever sees a single held digit or nothing.
- Also emits a one-cycle key-press strobe and a binary key code for display and debug.

Parameters:
- DEBOUNCE_CYCLES, 16: consecutive identical synchronised samples required before a change is accepted. Minimum 2.
- CNT_WIDTH, 5: width of each debounce counter. Must hold DEBOUNCE_CYCLES.

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- raw_b  input  10  raw digit buttons, active-high, asynchronous; bit i = digit i.
- raw_program  input  1  raw program button, active-high, asynchronous.
- b  output  10  debounced digit level, at most one bit set; bit i = digit i. Feeds lock inputs b0..b9.
- program_out  output  1  debounced program button level.
- key_press  output  1  one-cycle strobe when a valid single key is accepted.
- key_code  output  4  binary index (0-9) of the last accepted key; holds until the next accept.
- multi_key  output  1  high while in BLOCK.

Behaviour:
- Reset: while reset=0, all registers clear immediately (async). That includes the sync flops, debounce counters, the stable vectors, and FSM = IDLE. Outputs are then b=0, program_out=0, key_press=0, key_code=0, multi_key=0.
- Synchronisers: two-flop synchroniser on each of the 11 raw inputs; reset value 0.
- Digit debounce: one shared counter for the 10-bit digit vector.
  - On each edge, if the synchronised sample differs from the candidate register, load candidate = sample and counter = 1.
  - Otherwise, if counter < DEBOUNCE_CYCLES, increment it.
  - When counter reaches DEBOUNCE_CYCLES, stable_b = candidate; counter saturates.
  - Any glitch shorter than DEBOUNCE_CYCLES clocks never reaches stable_b.
- Program debounce: an identical, independent counter on the program bit produces program_out. No gating by digit state.
- FSM, registered outputs, states IDLE, KEY, BLOCK:
  - IDLE: b=0.
    - stable_b == 0: stay.
    - stable_b has exactly one bit set: go to KEY. On that same edge: b = stable_b, key_code = index, key_press = 1 for one cycle.
    - stable_b has two or more bits set: go to BLOCK.
  - KEY: b holds the accepted one-hot value.
    - stable_b equals the accepted value: stay.
    - stable_b == 0: go to IDLE, b=0.
    - Any other value (second key added, or roll-over to a different key): go to BLOCK, b=0. No key_press.
  - BLOCK: b=0, multi_key=1.
    - Stay until stable_b == 0, then go to IDLE.
    - A new key is accepted only after a full release.
- Latency: a clean raw edge appears on b (and key_press) exactly 2 + DEBOUNCE_CYCLES + 1 clocks later. Release latency is the same. program_out latency is 2 + DEBOUNCE_CYCLES.
- key_press is never asserted on two consecutive cycles. The minimum spacing between strobes is one full release plus one press debounce.
- Reset mid-press: outputs clear at once. After reset releases, a still-held key is re-accepted only after the full latency, and produces one key_press.
- Simultaneous digit and program presses are handled independently. The downstream FSM decides priority.
- Output invariant, checked by assertion: b is zero or one-hot in every cycle.

Test Plan (DEBOUNCE_CYCLES=4, CNT_WIDTH=3, so latency = 7):
- Hold raw_b=10'h008 for 20 cycles, then release -> b=10'h008 and key_code=3 exactly 7 clocks after the press, with key_press=1 for one cycle. b=0 exactly 7 clocks after the release.
- Toggle raw_b[5] as 3-cycle pulses separated by 1-cycle lows -> b stays 0, key_press never asserts. Raw glitch shorter than 4 samples.
- Hold raw_b=10'h001, then add bit 9 (10'h201) after 15 cycles -> b drops to 0 and multi_key=1. Releasing bit 9 only leaves the FSM in BLOCK. Full release -> IDLE, multi_key=0.
- Press raw_b=10'h006 (two keys simultaneously) -> BLOCK, b=0, no key_press, key_code keeps its old value.
- Hold raw_program=1 for 10 cycles during an active digit press -> program_out=1 from 6 clocks after assertion; b is unaffected.
- Hold raw_b=10'h010 until b=10'h010, pulse reset low for 1 cycle while holding -> b=0 immediately. b=10'h010 with a single key_press 7 clocks after reset deasserts.
